// File: rtl/obc_bitplane_sequencer.sv
// Bit-plane sequencer for one OBC ROM-accumulate lane.
// Captures 16 samples, presents planes MSB first, shift-accumulates rom_in.
// Ports: clk, rst_n, start, sample_in[16*DATA_W] -> busy, slice_out[16],
//        msb_flag ; rom_in[ROM_W] (same-cycle ROM return) -> result, done.
module obc_bitplane_sequencer #(
    parameter int DATA_W = 8,
    parameter int ROM_W  = 32,
    parameter int OUT_W  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [16*DATA_W-1:0]  sample_in,
    output logic                  busy,
    output logic [15:0]           slice_out,
    output logic                  msb_flag,
    input  logic [ROM_W-1:0]      rom_in,
    output logic [OUT_W-1:0]      result,
    output logic                  done
);

    localparam int PW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [PW-1:0] PLANE_MSB = PW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [16*DATA_W-1:0] sample_reg;
    logic [PW-1:0]        plane;
    logic [OUT_W-1:0]     acc;
    logic [OUT_W-1:0]     acc_nx;
    logic [OUT_W-1:0]     rom_ext;

    // ROM sum is signed; the MSB-plane negation already happened in the ROM.
    assign rom_ext = {{(OUT_W-ROM_W){rom_in[ROM_W-1]}}, rom_in};
    assign acc_nx  = (acc << 1) + rom_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (plane == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_reg <= '0;
            plane      <= '0;
            acc        <= '0;
            result     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sample_reg <= sample_in;
                        acc        <= '0;
                        plane      <= PLANE_MSB;
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    if (plane == '0) begin
                        result <= acc_nx;
                    end else begin
                        plane <= plane - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode purely from registers, so the ROM path has no loop.
    always_comb begin
        slice_out = '0;
        msb_flag  = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        if (state == RUN) begin
            for (int k = 0; k < 16; k++) begin
                slice_out[k] = sample_reg[k*DATA_W + int'(plane)];
            end
            msb_flag = (plane == PLANE_MSB);
        end
    end

endmodule

// File: tb/tb_obc_bitplane_sequencer.sv
// Directed bench for obc_bitplane_sequencer with a popcount ROM stub.
// Stub makes result equal to the signed sum of the 16 samples.
module tb_obc_bitplane_sequencer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] sample_in = '0;
    logic         busy;
    logic [15:0]  slice_out;
    logic         msb_flag;
    logic [31:0]  rom_in;
    logic [39:0]  result;
    logic         done;

    logic [31:0]  pc32;
    logic [7:0]   smp [16];
    logic [39:0]  prev_res;

    int total = 0;
    int bad = 0;

    obc_bitplane_sequencer #(
        .DATA_W(8),
        .ROM_W(32),
        .OUT_W(40)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .sample_in(sample_in),
        .busy(busy),
        .slice_out(slice_out),
        .msb_flag(msb_flag),
        .rom_in(rom_in),
        .result(result),
        .done(done)
    );

    always #5 clk = ~clk;

    always_comb begin
        pc32 = 32'($countones(slice_out));
        rom_in = msb_flag ? -pc32 : pc32;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack();
        logic [127:0] p;
        for (int k = 0; k < 16; k++) p[k*8 +: 8] = smp[k];
        return p;
    endfunction

    task automatic set_all(input logic [7:0] v);
        for (int k = 0; k < 16; k++) smp[k] = v;
    endtask

    // Full run; poke re-pulses start and scrambles sample_in mid-run.
    task automatic run(input string tag, input logic [39:0] exp_res,
                       input bit poke);
        logic [7:0]  cap [16];
        logic [15:0] es;
        int j;
        cap = smp;
        sample_in = pack();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            j = 8 - n;
            if (n <= 8) begin
                for (int k = 0; k < 16; k++) es[k] = cap[k][j];
                chk({tag, "_slice"}, 64'(slice_out), 64'(es));
                chk({tag, "_msb"}, 64'(msb_flag), 64'(j == 7));
                chk({tag, "_busy"}, 64'(busy), 64'd1);
                chk({tag, "_done0"}, 64'(done), 64'd0);
                if (n == 1)
                    chk({tag, "_hold"}, 64'(result), 64'(prev_res));
            end else begin
                chk({tag, "_done"}, 64'(done), 64'd1);
                chk({tag, "_busyd"}, 64'(busy), 64'd1);
                chk({tag, "_slice0"}, 64'(slice_out), 64'd0);
                chk({tag, "_msb0"}, 64'(msb_flag), 64'd0);
                chk({tag, "_res"}, 64'(result), 64'(exp_res));
            end
            if (poke && (n == 3 || n == 9)) begin
                start = 1'b1;
                sample_in = ~sample_in;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_idle_done"}, 64'(done), 64'd0);
        chk({tag, "_held"}, 64'(result), 64'(exp_res));
        prev_res = exp_res;
    endtask

    initial begin
        prev_res = '0;
        set_all(8'h00);
        #3;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_slice", 64'(slice_out), 64'd0);
        chk("rst_msb", 64'(msb_flag), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 64'(busy), 64'd0);

        set_all(8'h00);
        run("zero", 40'd0, 1'b0);
        set_all(8'h01);
        run("ones", 40'd16, 1'b0);
        set_all(8'h80);
        run("neg", 40'hFF_FFFF_F800, 1'b0);
        for (int k = 0; k < 16; k++) smp[k] = 8'(k);
        run("ramp", 40'd120, 1'b1);
        set_all(8'h7F);
        run("max", 40'd2032, 1'b0);

        // abort a run at plane 4 with an asynchronous reset
        for (int k = 0; k < 16; k++) smp[k] = 8'(k + 3);
        sample_in = pack();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("ab_busy_pre", 64'(busy), 64'd1);
        chk("ab_msb_pre", 64'(msb_flag), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_busy", 64'(busy), 64'd0);
        chk("ab_slice", 64'(slice_out), 64'd0);
        chk("ab_msb", 64'(msb_flag), 64'd0);
        chk("ab_done", 64'(done), 64'd0);
        chk("ab_res", 64'(result), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_res = '0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            chk("ab_nodone", 64'(done), 64'd0);
            chk("ab_idle", 64'(busy), 64'd0);
        end
        set_all(8'h01);
        run("fresh", 40'd16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obc_bitplane_sequencer.md
Name: obc_bitplane_sequencer

Overview:
- Drives the bit-plane side of the OBC ROM-accumulate interface and reads back its 32-bit partial sum.
- Captures 16 two's-complement samples, then presents one bit-plane per cycle on slice_out/msb_flag, MSB plane first.
- Shift-accumulates the returned rom_in into a wide result, then pulses done.
- Sits between the sample buffer of the 16-point DFT and one ROM-accumulate lane; one instance per DFT output bin/part.

Parameters:
- DATA_W, 8, sample width in bits (two's complement), also the number of bit-planes.
- ROM_W, 32, width of rom_in.
- OUT_W, 40, result width; must be >= ROM_W+DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to capture samples and begin; honoured only in IDLE.
- sample_in  input  16*DATA_W  sample k at bits [k*DATA_W +: DATA_W], k=0..15.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- slice_out  output  16  bit j of sample k on slice_out[k]; drives ROM x0k inputs.
- msb_flag  output  1  high only while the MSB plane is presented; drives ROM m input.
- rom_in  input  ROM_W  signed ROM partial sum for the currently presented plane (combinational return, same cycle).
- result  output  OUT_W  signed accumulated output, held until the next accepted start.
- done  output  1  one-cycle pulse when result becomes valid.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, slice_out=0, msb_flag=0, result=0, accumulator=0, plane counter=0, sample register=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - slice_out=0, msb_flag=0.
  - On start=1, register sample_in, clear the accumulator, set plane j=DATA_W-1 and go to RUN.
- RUN, one cycle per plane:
  - slice_out[k] = sample_reg[k][j] (registered outputs); msb_flag = (j==DATA_W-1).
  - Each RUN cycle: acc <= (acc<<1) + sext(rom_in) to OUT_W. The first plane starts from acc=0.
  - When j==0, the add completes, result <= new acc, and the state goes to DONE. Otherwise j <= j-1.
- DONE:
  - done=1 for exactly one cycle; busy=1; slice_out=0, msb_flag=0.
  - Next state is IDLE.
- Latency: start sampled high at edge T gives plane MSB in cycle T+1 and plane 0 in cycle T+DATA_W. done and the new result are visible in cycle T+DATA_W+1. The next start is accepted at edge T+DATA_W+2 at the earliest.
- start during RUN or DONE is ignored: no recapture, no restart, and no queuing.
- sample_in changes after capture have no effect on the current run.
- Arithmetic:
  - rom_in is treated as signed and sign-extended before the add.
  - Shift and add are modulo 2^OUT_W. OUT_W=40 is sufficient for the full rom_in range, so no saturation is applied.
  - Sign handling for the MSB plane belongs to the ROM via msb_flag. This block does not negate.
- result changes only on the final-plane edge; it keeps its previous value through IDLE and RUN.
- Reset mid-RUN: all outputs return to reset values immediately, and no done pulse is produced for the aborted run.
- rom_in is ignored outside RUN.

Test Plan:
- Bench ROM stub: rom_in = popcount(slice_out), negated when msb_flag=1. result then equals the signed sum of the 16 samples.
- Reset: assert rst_n=0 mid-cycle -> busy=0, done=0, slice_out=0, msb_flag=0, result=0, all asynchronously.
- All samples 0, start at T -> slice_out=0 for 8 RUN cycles, done at T+9, result=0.
- All samples 1 -> slice_out=0xFFFF only in the plane-0 cycle (T+8), msb_flag only at T+1, result=16.
- All samples -128 (0x80) -> slice_out=0xFFFF with msb_flag=1 at T+1, then 0, result=-2048 (0xFFFFFFF800).
- Samples k=0..15 set to k, with start re-pulsed at T+3 and sample_in changed mid-run -> the extra start is ignored, done only at T+9, result=120. A second start at T+10 with samples all 127 -> done at T+19, result=2032.
- Reset asserted during RUN plane 4, released, then a new start with samples all 1 -> no done for the aborted run, result=16 after the fresh 9-cycle run.
